// File: rtl/axi_mem_responder_pkg.sv
// Shared types and encodings for the AXI memory responder.
package axi_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    WRESP = 2'd3
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  // Severity merge; the encodings are already ordered OKAY < SLVERR < DECERR.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_mem_responder_ram.sv
// Word-addressed storage: byte-strobed synchronous write, combinational read.
// Contents are deliberately not reset.
module axi_mem_responder_ram #(
  parameter int unsigned Depth     = 4096,
  parameter int unsigned DataWidth = 64
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(Depth)-1:0]     idx,
  input  logic [DataWidth-1:0]         wdata,
  input  logic [DataWidth/8-1:0]       strb,
  output logic [DataWidth-1:0]         rdata
);

  logic [DataWidth-1:0] mem [Depth];

  // Byte-lane write of the strobed bytes
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DataWidth / 8; b++) begin
        if (strb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 responder serving one transaction at a time from an internal memory.
// DataWidth is expected to be 32 or 64; Depth a power of two.
//
// state | meaning
// IDLE  | both address channels may be accepted; read/write arbitration
// READ  | streaming read beats on R, one per accepted r_ready
// WRITE | accepting W beats until beat == len
// WRESP | presenting the accumulated write response on B
module axi_mem_responder
  import axi_mem_responder_pkg::*;
#(
  parameter int unsigned          IdWidth   = 4,
  parameter int unsigned          AddrWidth = 64,
  parameter int unsigned          DataWidth = 64,
  parameter int unsigned          Depth     = 4096,
  parameter logic [AddrWidth-1:0] BaseAddr  = AddrWidth'(64'h8000_0000)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [IdWidth-1:0]     aw_id_i,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic [7:0]             aw_len_i,
  input  logic [1:0]             aw_burst_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  input  logic [DataWidth-1:0]   w_data_i,
  input  logic [DataWidth/8-1:0] w_strb_i,
  input  logic                   w_last_i,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  output logic [IdWidth-1:0]     b_id_o,
  output logic [1:0]             b_resp_o,
  input  logic                   ar_valid_i,
  output logic                   ar_ready_o,
  input  logic [IdWidth-1:0]     ar_id_i,
  input  logic [AddrWidth-1:0]   ar_addr_i,
  input  logic [7:0]             ar_len_i,
  input  logic [1:0]             ar_burst_i,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [IdWidth-1:0]     r_id_o,
  output logic [DataWidth-1:0]   r_data_o,
  output logic [1:0]             r_resp_o,
  output logic                   r_last_o
);

  localparam int unsigned          NumBytes = DataWidth / 8;
  localparam int unsigned          OffW     = $clog2(NumBytes);
  localparam int unsigned          IdxW     = $clog2(Depth);
  localparam logic [AddrWidth-1:0] Span     = AddrWidth'(Depth * NumBytes);
  localparam logic [AddrWidth-1:0] BeatStep = AddrWidth'(NumBytes);

  state_e                 state_q, state_d;
  logic                   prio_rd_q, prio_rd_d;
  logic [IdWidth-1:0]     id_q, id_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [7:0]             len_q, len_d, beat_q, beat_d;
  logic [1:0]             burst_q, burst_d, err_q, err_d;

  logic [AddrWidth-1:0]   offset, next_addr;
  logic                   in_range, bad_burst, last_beat, ram_we;
  logic [1:0]             beat_resp;
  logic [IdxW-1:0]        idx;
  logic [DataWidth-1:0]   ram_rdata;

  // Beat decode: range check and word index both come from the registered address.
  assign offset    = addr_q - BaseAddr;
  assign in_range  = (addr_q >= BaseAddr) && (offset < Span);
  assign idx       = offset[OffW +: IdxW];
  assign bad_burst = (burst_q != BURST_FIXED) && (burst_q != BURST_INCR);
  assign beat_resp = resp_max(bad_burst ? RESP_SLVERR : RESP_OKAY,
                              in_range  ? RESP_OKAY   : RESP_DECERR);
  assign last_beat = (beat_q == len_q);
  assign next_addr = (burst_q == BURST_INCR) ? addr_q + BeatStep : addr_q;

  axi_mem_responder_ram #(
    .Depth     (Depth),
    .DataWidth (DataWidth)
  ) u_ram (
    .clk   (clk_i),
    .we    (ram_we),
    .idx   (idx),
    .wdata (w_data_i),
    .strb  (w_strb_i),
    .rdata (ram_rdata)
  );

  // State and transaction context registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      prio_rd_q <= 1'b1;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      err_q     <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      prio_rd_q <= prio_rd_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
    end
  end

  // Next-state, arbitration and all channel outputs
  always_comb begin
    state_d    = state_q;
    prio_rd_d  = prio_rd_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    burst_d    = burst_q;
    beat_d     = beat_q;
    err_d      = err_q;
    ar_ready_o = 1'b0;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    b_id_o     = '0;
    b_resp_o   = RESP_OKAY;
    r_valid_o  = 1'b0;
    r_id_o     = '0;
    r_data_o   = '0;
    r_resp_o   = RESP_OKAY;
    r_last_o   = 1'b0;
    ram_we     = 1'b0;
    case (state_q)
      IDLE: begin
        // Readies are held low while reset is asserted, even though IDLE is forced.
        if (rst_ni) begin
          ar_ready_o = !(ar_valid_i && aw_valid_i && !prio_rd_q);
          aw_ready_o = !(ar_valid_i && aw_valid_i && prio_rd_q);
          if (ar_valid_i && aw_valid_i) prio_rd_d = !prio_rd_q;
          if (ar_valid_i && ar_ready_o) begin
            id_d    = ar_id_i;
            addr_d  = ar_addr_i;
            len_d   = ar_len_i;
            burst_d = ar_burst_i;
            beat_d  = '0;
            err_d   = RESP_OKAY;
            state_d = READ;
          end else if (aw_valid_i && aw_ready_o) begin
            id_d    = aw_id_i;
            addr_d  = aw_addr_i;
            len_d   = aw_len_i;
            burst_d = aw_burst_i;
            beat_d  = '0;
            err_d   = RESP_OKAY;
            state_d = WRITE;
          end
        end
      end
      READ: begin
        r_valid_o = 1'b1;
        r_id_o    = id_q;
        r_resp_o  = beat_resp;
        r_last_o  = last_beat;
        r_data_o  = (beat_resp == RESP_OKAY) ? ram_rdata : '0;
        if (r_ready_i) begin
          beat_d = beat_q + 8'd1;
          addr_d = next_addr;
          if (last_beat) state_d = IDLE;
        end
      end
      WRITE: begin
        w_ready_o = 1'b1;
        if (w_valid_i) begin
          ram_we = (beat_resp == RESP_OKAY);
          err_d  = resp_max(resp_max(err_q, beat_resp),
                            (w_last_i != last_beat) ? RESP_SLVERR : RESP_OKAY);
          beat_d = beat_q + 8'd1;
          addr_d = next_addr;
          if (last_beat) state_d = WRESP;
        end
      end
      WRESP: begin
        b_valid_o = 1'b1;
        b_id_o    = id_q;
        b_resp_o  = err_q;
        if (b_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder with a response scoreboard.
module tb_axi_mem_responder;
  import axi_mem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [3:0]  aw_id, ar_id, b_id, r_id;
  logic [63:0] aw_addr, ar_addr, w_data, r_data;
  logic [7:0]  aw_len, ar_len, w_strb;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;

  typedef struct {
    logic        rd;
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  localparam logic [63:0] W0 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] W1 = 64'h0101_0202_0303_0404;
  localparam logic [63:0] W2 = 64'h0505_0606_0707_0808;
  localparam logic [63:0] W3 = 64'hCAFE_F00D_DEAD_BEEF;
  localparam logic [63:0] W4 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] E0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] E1 = 64'h5555_6666_7777_8888;

  always #5 clk = ~clk;

  axi_mem_responder dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .aw_valid_i (aw_valid),
    .aw_ready_o (aw_ready),
    .aw_id_i    (aw_id),
    .aw_addr_i  (aw_addr),
    .aw_len_i   (aw_len),
    .aw_burst_i (aw_burst),
    .w_valid_i  (w_valid),
    .w_ready_o  (w_ready),
    .w_data_i   (w_data),
    .w_strb_i   (w_strb),
    .w_last_i   (w_last),
    .b_valid_o  (b_valid),
    .b_ready_i  (b_ready),
    .b_id_o     (b_id),
    .b_resp_o   (b_resp),
    .ar_valid_i (ar_valid),
    .ar_ready_o (ar_ready),
    .ar_id_i    (ar_id),
    .ar_addr_i  (ar_addr),
    .ar_len_i   (ar_len),
    .ar_burst_i (ar_burst),
    .r_valid_o  (r_valid),
    .r_ready_i  (r_ready),
    .r_id_o     (r_id),
    .r_data_o   (r_data),
    .r_resp_o   (r_resp),
    .r_last_o   (r_last)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout want handshake", name);
  endtask

  task automatic push_r(input logic [3:0] id, input logic [63:0] data, input logic [1:0] resp,
                        input logic last);
    exp_t e;
    e.rd = 1'b1; e.id = id; e.data = data; e.resp = resp; e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
    exp_t e;
    e.rd = 1'b0; e.id = id; e.data = '0; e.resp = resp; e.last = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int n = 0;
    ar_id = id; ar_addr = addr; ar_len = len; ar_burst = burst; ar_valid = 1'b1;
    @(negedge clk);
    while (!ar_ready && n < 200) begin @(negedge clk); n++; end
    if (!ar_ready) timeout("ar_handshake");
    @(posedge clk); #1 ar_valid = 1'b0;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int n = 0;
    aw_id = id; aw_addr = addr; aw_len = len; aw_burst = burst; aw_valid = 1'b1;
    @(negedge clk);
    while (!aw_ready && n < 200) begin @(negedge clk); n++; end
    if (!aw_ready) timeout("aw_handshake");
    @(posedge clk); #1 aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n = 0;
    w_data = data; w_strb = strb; w_last = last; w_valid = 1'b1;
    @(negedge clk);
    while (!w_ready && n < 200) begin @(negedge clk); n++; end
    if (!w_ready) timeout("w_handshake");
    @(posedge clk); #1 w_valid = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [63:0] d0, input logic [63:0] d1,
                          input logic [63:0] d2, input logic [63:0] d3, input logic [7:0] strb,
                          input logic [3:0] lastm);
    logic [63:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    send_aw(id, addr, len, burst);
    for (int i = 0; i <= int'(len) && i < 4; i++) send_w(d[i], strb, lastm[i]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      timeout("drain");
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: pops one expectation per completed R or B handshake.
  always @(negedge clk) begin
    if (rst_n && r_valid && r_ready) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL r_unexpected: got id=%0h data=%h want no beat", r_id, r_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("r_beat", {1'b1, r_id, r_data, r_resp, r_last},
              {mon_e.rd, mon_e.id, mon_e.data, mon_e.resp, mon_e.last});
      end
    end
    if (rst_n && b_valid && b_ready) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL b_unexpected: got id=%0h resp=%0h want no response", b_id, b_resp);
      end else begin
        mon_e = exp_q.pop_front();
        check("b_resp", {1'b0, b_id, 64'h0, b_resp, 1'b0},
              {mon_e.rd, mon_e.id, mon_e.data, mon_e.resp, mon_e.last});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_burst = 0;
    ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_burst = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0;
    r_ready = 1'b1; b_ready = 1'b1;
    #2;
    check("rst_handshake", {ar_ready, aw_ready, w_ready, r_valid, b_valid}, 5'b0);
    check("rst_rdata", r_data, 64'h0);
    check("rst_misc", {r_id, b_id, r_resp, b_resp, r_last}, 13'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_readies", {ar_ready, aw_ready}, 2'b11);
    @(posedge clk); #1;

    // Single-beat write then readback
    push_b(4'd3, RESP_OKAY);
    do_write(4'd3, 64'h8000_0000, 8'd0, BURST_INCR, W0, 0, 0, 0, 8'hFF, 4'b0001);
    push_r(4'd3, W0, RESP_OKAY, 1'b1);
    send_ar(4'd3, 64'h8000_0000, 8'd0, BURST_INCR);
    wait_idle();

    // Two-beat read with back-pressure on the first beat
    push_b(4'd1, RESP_OKAY);
    do_write(4'd1, 64'h8000_0008, 8'd1, BURST_INCR, W1, W2, 0, 0, 8'hFF, 4'b0010);
    wait_idle();
    r_ready = 1'b0;
    push_r(4'd5, W1, RESP_OKAY, 1'b0);
    push_r(4'd5, W2, RESP_OKAY, 1'b1);
    send_ar(4'd5, 64'h8000_0008, 8'd1, BURST_INCR);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold", {r_valid, r_id, r_data, r_resp, r_last}, {1'b1, 4'd5, W1, RESP_OKAY, 1'b0});
    end
    @(posedge clk); #1 r_ready = 1'b1;
    wait_idle();

    // Simultaneous AR/AW: read wins first, then write wins
    push_r(4'd6, W0, RESP_OKAY, 1'b1);
    push_b(4'd7, RESP_OKAY);
    fork
      send_ar(4'd6, 64'h8000_0000, 8'd0, BURST_INCR);
      do_write(4'd7, 64'h8000_0018, 8'd0, BURST_INCR, W3, 0, 0, 0, 8'hFF, 4'b0001);
      begin @(negedge clk); check("arb_first", {ar_ready, aw_ready}, 2'b10); end
    join
    wait_idle();
    push_b(4'd8, RESP_OKAY);
    push_r(4'd9, W3, RESP_OKAY, 1'b1);
    fork
      send_ar(4'd9, 64'h8000_0018, 8'd0, BURST_INCR);
      do_write(4'd8, 64'h8000_0020, 8'd0, BURST_INCR, W4, 0, 0, 0, 8'hFF, 4'b0001);
      begin @(negedge clk); check("arb_second", {ar_ready, aw_ready}, 2'b01); end
    join
    wait_idle();

    // Read crossing from below the window into it
    push_r(4'd2, 64'h0, RESP_DECERR, 1'b0);
    push_r(4'd2, W0, RESP_OKAY, 1'b1);
    send_ar(4'd2, 64'h7FFF_FFF8, 8'd1, BURST_INCR);
    wait_idle();

    // WRAP write is refused and leaves memory untouched
    push_b(4'd4, RESP_SLVERR);
    do_write(4'd4, 64'h8000_0000, 8'd3, BURST_WRAP, 64'hDEAD, 64'hDEAD, 64'hDEAD, 64'hDEAD,
             8'hFF, 4'b1000);
    push_r(4'd4, W0, RESP_OKAY, 1'b1);
    send_ar(4'd4, 64'h8000_0000, 8'd0, BURST_INCR);
    wait_idle();

    // Early w_last: data still written, response SLVERR
    push_b(4'd1, RESP_SLVERR);
    do_write(4'd1, 64'h8000_0030, 8'd1, BURST_INCR, E0, E1, 0, 0, 8'hFF, 4'b0011);
    push_r(4'd1, E0, RESP_OKAY, 1'b0);
    push_r(4'd1, E1, RESP_OKAY, 1'b1);
    send_ar(4'd1, 64'h8000_0030, 8'd1, BURST_INCR);
    wait_idle();

    // Partial strobe over an all-ones word
    push_b(4'd2, RESP_OKAY);
    do_write(4'd2, 64'h8000_0040, 8'd0, BURST_INCR, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 8'hFF, 4'b0001);
    push_b(4'd2, RESP_OKAY);
    do_write(4'd2, 64'h8000_0040, 8'd0, BURST_INCR, 64'hAAAA_AAAA_1234_5678, 0, 0, 0, 8'h0F, 4'b0001);
    push_r(4'd2, 64'hFFFF_FFFF_1234_5678, RESP_OKAY, 1'b1);
    send_ar(4'd2, 64'h8000_0040, 8'd0, BURST_INCR);
    wait_idle();

    // Reset during beat 2 of a four-beat read
    push_r(4'd6, W0, RESP_OKAY, 1'b0);
    push_r(4'd6, W1, RESP_OKAY, 1'b0);
    send_ar(4'd6, 64'h8000_0000, 8'd3, BURST_INCR);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_rvalid", {r_valid, r_last, r_resp}, 4'b0);
    check("rst_mid_rdata", r_data, 64'h0);
    check("rst_mid_queue", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {ar_ready, aw_ready, r_valid}, 3'b110);
    @(posedge clk); #1;
    push_r(4'd7, 64'hFFFF_FFFF_1234_5678, RESP_OKAY, 1'b1);
    send_ar(4'd7, 64'h8000_0040, 8'd0, BURST_INCR);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
